rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- ALU reservation station: buffers dispatched integer/branch/jump instructions until both source operands are available.
- Snoops two CDBs for wake-up: the ALU result bus and the load/store result bus.
- Issues at most one ready instruction per cycle to the combinational EX unit, which then broadcasts on the ALU CDB.
- Sits between dispatch/rename (upstream) and EX (downstream).

Parameters:
- DEPTH, 8, number of RS entries (power of two, 2..16).
- IDX_W, 3, log2(DEPTH).
- ROB_W, 5, ROB tag width; ROB holds 32 entries.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_i  in  1  mispredict flush; invalidates all entries.
- disp_en_i  in  1  dispatch valid.
- disp_OP_i / disp_Funct7_i / disp_Funct3_i  in  7/7/3  decoded opcode fields.
- disp_Imm_i / disp_pc_i  in  32/32  immediate, instruction PC.
- disp_ROB_id_i  in  ROB_W  destination ROB tag.
- disp_Qj_busy_i / disp_Qj_i / disp_Vj_i  in  1/ROB_W/32  rs1: still pending, producer tag, value if ready.
- disp_Qk_busy_i / disp_Qk_i / disp_Vk_i  in  1/ROB_W/32  rs2, same meaning.
- cdb_en_i / cdb_id_ROB_i / cdb_data_i  in  1/ROB_W/32  ALU CDB (from EX).
- lsb_cdb_en_i / lsb_cdb_id_ROB_i / lsb_cdb_data_i  in  1/ROB_W/32  load CDB.
- full_o  out  1  no free entry; dispatch must stall.
- en_o  out  1  issue valid to EX.
- A_o / B_o / Imm_o / pc_o  out  32 each  operands to EX.
- OP_o / Funct7_o / Funct3_o  out  7/7/3  opcode fields to EX.
- ROB_id_o  out  ROB_W  destination tag to EX.

Behaviour:
- Entry state: busy, Qj_busy, Qj, Vj, Qk_busy, Qk, Vk, OP, Funct7, Funct3, Imm, pc, ROB_id.
- Reset/flush: on rst or clear_i at an edge, all busy=0 and all outputs 0 (en_o=0, buses 0). rst and clear_i override dispatch, wake-up and issue in that cycle.
- full_o: combinational, =1 iff every entry busy in the current (pre-edge) state. A slot freed by an issue at this edge is not reusable by a dispatch at the same edge.
- Dispatch: disp_en_i && !full_o writes the lowest-index non-busy entry. disp_en_i while full_o is ignored; no state change.
- Dispatch-time bypass: if Qj_busy and a CDB in the same cycle carries tag Qj, store its data as Vj with Qj_busy=0. Same for Qk. ALU CDB has priority if both buses match.
- Wake-up: each edge, every busy entry with Qx_busy && cdb_en && Qx==tag captures data and clears Qx_busy. Both CDBs are checked; they never carry the same tag (ROB guarantees).
- Ready: busy && !Qj_busy && !Qk_busy, from registered state only. No wake-up-to-issue bypass in the same cycle.
- Issue: each edge, if any entry is ready, the lowest-index ready entry drives registered outputs (A_o=Vj, B_o=Vk, fields copied), en_o=1, and the entry is freed. Otherwise en_o=0 and buses are 0.
- Latency:
  - Dispatch with both operands ready at edge E -> en_o high in the cycle after E+1.
  - Wake-up at edge E -> earliest en_o in the cycle after E+1.
- Operand-less ops (LUI/AUIPC/JAL): dispatch supplies Qj_busy=Qk_busy=0; the RS treats all opcodes uniformly.
- en_o is a single-cycle pulse per issued instruction; EX has no backpressure.
- Dispatch, wake-up and issue to different entries at the same edge all take effect.

Decomposition:
- Shared package cpu_pkg: XLEN=32, ROB_W=5, opcode localparams (OP_LUI 0110111, OP_AUIPC 0010111, OP_IMM 0010011, OP_REG 0110011, OP_JALR 1100111, OP_JAL 1101111, OP_BRANCH 1100011).
- Sub-module rs_prio_enc (parameter DEPTH): lowest-index-set priority encoder with a found flag. Instantiated twice: free-slot search and ready-slot search.

Test Plan:
- Reset: assert rst 2 cycles mid-operation with 3 busy entries -> en_o=0, full_o=0, all buses 0; a later issue never emits the old tags.
- Ready dispatch: ADDI, Vj=5, Imm=7, ROB_id=3 at edge E -> en_o=1, A_o=5, Imm_o=7, ROB_id_o=3 in the cycle after E+1 only.
- Wake-up:
  - Dispatch ADD with Qj_busy=1, Qj=9, Vk=2.
  - Two cycles later, lsb_cdb tag 9 with data 0x100.
  - -> issue next cycle with A_o=0x100, B_o=2.
- Dispatch bypass: dispatch with Qk=4 busy while cdb_en_i, tag 4, data 0xDEAD in the same cycle -> issued with B_o=0xDEAD, no further wait.
- Full/order: dispatch 8 entries all with Qj pending -> full_o=1; 9th dispatch ignored. Wake entries 5 and 2 together -> entry 2 issues first, then entry 5; full_o drops to 0 after the first issue.
- Flush: with 4 busy entries, pulse clear_i together with disp_en_i -> all entries empty, the new dispatch is dropped, en_o=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, ROB tag width and the RV32I opcodes
// that reach the ALU reservation station.
package cpu_pkg;
  localparam int XLEN  = 32;
  localparam int ROB_W = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set priority encoder with a found flag; used for free-slot
// and ready-slot selection in the reservation station.
module rs_prio_enc #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);
  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ALU/branch/jump ops until both
// operands arrive over the ALU or load/store CDB, then issues one per cycle.
module rs_alu
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int ROB_W = cpu_pkg::ROB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             disp_en_i,
  input  logic [6:0]       disp_OP_i,
  input  logic [6:0]       disp_Funct7_i,
  input  logic [2:0]       disp_Funct3_i,
  input  logic [XLEN-1:0]  disp_Imm_i,
  input  logic [XLEN-1:0]  disp_pc_i,
  input  logic [ROB_W-1:0] disp_ROB_id_i,
  input  logic             disp_Qj_busy_i,
  input  logic [ROB_W-1:0] disp_Qj_i,
  input  logic [XLEN-1:0]  disp_Vj_i,
  input  logic             disp_Qk_busy_i,
  input  logic [ROB_W-1:0] disp_Qk_i,
  input  logic [XLEN-1:0]  disp_Vk_i,
  input  logic             cdb_en_i,
  input  logic [ROB_W-1:0] cdb_id_ROB_i,
  input  logic [XLEN-1:0]  cdb_data_i,
  input  logic             lsb_cdb_en_i,
  input  logic [ROB_W-1:0] lsb_cdb_id_ROB_i,
  input  logic [XLEN-1:0]  lsb_cdb_data_i,
  output logic             full_o,
  output logic             en_o,
  output logic [XLEN-1:0]  A_o,
  output logic [XLEN-1:0]  B_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [6:0]       OP_o,
  output logic [6:0]       Funct7_o,
  output logic [2:0]       Funct3_o,
  output logic [ROB_W-1:0] ROB_id_o
);
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_qj_busy;
  logic [DEPTH-1:0] r_qk_busy;
  logic [ROB_W-1:0] r_qj  [DEPTH];
  logic [ROB_W-1:0] r_qk  [DEPTH];
  logic [ROB_W-1:0] r_rob [DEPTH];
  logic [XLEN-1:0]  r_vj  [DEPTH];
  logic [XLEN-1:0]  r_vk  [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [XLEN-1:0]  r_pc  [DEPTH];
  logic [6:0]       r_op  [DEPTH];
  logic [6:0]       r_f7  [DEPTH];
  logic [2:0]       r_f3  [DEPTH];

  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_ready;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_rdy_idx;
  logic             w_free_found;
  logic             w_rdy_found;
  logic             w_disp_fire;
  logic             w_qj_hit_alu, w_qj_hit_lsb, w_qk_hit_alu, w_qk_hit_lsb;
  logic             w_disp_qj_busy, w_disp_qk_busy;
  logic [XLEN-1:0]  w_disp_vj, w_disp_vk;

  // Readiness looks only at registered state, so a wake-up never issues in the same cycle.
  assign w_free      = ~r_busy;
  assign w_ready     = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign full_o      = &r_busy;
  assign w_disp_fire = disp_en_i && !full_o;

  rs_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .i_req   (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rdy_enc (
    .i_req   (w_ready),
    .o_idx   (w_rdy_idx),
    .o_found (w_rdy_found)
  );

  // Dispatch-time bypass; the ALU CDB wins if both buses match.
  assign w_qj_hit_alu   = cdb_en_i && (cdb_id_ROB_i == disp_Qj_i);
  assign w_qj_hit_lsb   = lsb_cdb_en_i && (lsb_cdb_id_ROB_i == disp_Qj_i);
  assign w_qk_hit_alu   = cdb_en_i && (cdb_id_ROB_i == disp_Qk_i);
  assign w_qk_hit_lsb   = lsb_cdb_en_i && (lsb_cdb_id_ROB_i == disp_Qk_i);
  assign w_disp_qj_busy = disp_Qj_busy_i && !w_qj_hit_alu && !w_qj_hit_lsb;
  assign w_disp_qk_busy = disp_Qk_busy_i && !w_qk_hit_alu && !w_qk_hit_lsb;
  assign w_disp_vj = !disp_Qj_busy_i ? disp_Vj_i :
                     w_qj_hit_alu    ? cdb_data_i :
                     w_qj_hit_lsb    ? lsb_cdb_data_i : disp_Vj_i;
  assign w_disp_vk = !disp_Qk_busy_i ? disp_Vk_i :
                     w_qk_hit_alu    ? cdb_data_i :
                     w_qk_hit_lsb    ? lsb_cdb_data_i : disp_Vk_i;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_busy   <= '0;
      en_o     <= 1'b0;
      A_o      <= '0;
      B_o      <= '0;
      Imm_o    <= '0;
      pc_o     <= '0;
      OP_o     <= '0;
      Funct7_o <= '0;
      Funct3_o <= '0;
      ROB_id_o <= '0;
    end else begin
      if (w_rdy_found) begin
        en_o              <= 1'b1;
        A_o               <= r_vj[w_rdy_idx];
        B_o               <= r_vk[w_rdy_idx];
        Imm_o             <= r_imm[w_rdy_idx];
        pc_o              <= r_pc[w_rdy_idx];
        OP_o              <= r_op[w_rdy_idx];
        Funct7_o          <= r_f7[w_rdy_idx];
        Funct3_o          <= r_f3[w_rdy_idx];
        ROB_id_o          <= r_rob[w_rdy_idx];
        r_busy[w_rdy_idx] <= 1'b0;
      end else begin
        en_o     <= 1'b0;
        A_o      <= '0;
        B_o      <= '0;
        Imm_o    <= '0;
        pc_o     <= '0;
        OP_o     <= '0;
        Funct7_o <= '0;
        Funct3_o <= '0;
        ROB_id_o <= '0;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && r_qj_busy[i]) begin
          if (cdb_en_i && (r_qj[i] == cdb_id_ROB_i)) begin
            r_vj[i]      <= cdb_data_i;
            r_qj_busy[i] <= 1'b0;
          end else if (lsb_cdb_en_i && (r_qj[i] == lsb_cdb_id_ROB_i)) begin
            r_vj[i]      <= lsb_cdb_data_i;
            r_qj_busy[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_busy[i]) begin
          if (cdb_en_i && (r_qk[i] == cdb_id_ROB_i)) begin
            r_vk[i]      <= cdb_data_i;
            r_qk_busy[i] <= 1'b0;
          end else if (lsb_cdb_en_i && (r_qk[i] == lsb_cdb_id_ROB_i)) begin
            r_vk[i]      <= lsb_cdb_data_i;
            r_qk_busy[i] <= 1'b0;
          end
        end
      end

      // The free slot comes from pre-edge state, so it never collides with the issued one.
      if (w_disp_fire && w_free_found) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_qj_busy[w_free_idx] <= w_disp_qj_busy;
        r_qk_busy[w_free_idx] <= w_disp_qk_busy;
        r_qj[w_free_idx]      <= disp_Qj_i;
        r_qk[w_free_idx]      <= disp_Qk_i;
        r_vj[w_free_idx]      <= w_disp_vj;
        r_vk[w_free_idx]      <= w_disp_vk;
        r_imm[w_free_idx]     <= disp_Imm_i;
        r_pc[w_free_idx]      <= disp_pc_i;
        r_op[w_free_idx]      <= disp_OP_i;
        r_f7[w_free_idx]      <= disp_Funct7_i;
        r_f3[w_free_idx]      <= disp_Funct3_i;
        r_rob[w_free_idx]     <= disp_ROB_id_i;
      end
    end
  end
endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus random traffic, checked by a
// slot-level reference model feeding an expected-issue queue.
module tb_rs_alu;
  localparam int DEPTH = 8;
  localparam int REC_W = 32 + 5 + 32 * 4 + 7 + 7 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        disp_en_i = 1'b0;
  logic [6:0]  disp_OP_i = '0, disp_Funct7_i = '0;
  logic [2:0]  disp_Funct3_i = '0;
  logic [31:0] disp_Imm_i = '0, disp_pc_i = '0;
  logic [4:0]  disp_ROB_id_i = '0;
  logic        disp_Qj_busy_i = 1'b0, disp_Qk_busy_i = 1'b0;
  logic [4:0]  disp_Qj_i = '0, disp_Qk_i = '0;
  logic [31:0] disp_Vj_i = '0, disp_Vk_i = '0;
  logic        cdb_en_i = 1'b0, lsb_cdb_en_i = 1'b0;
  logic [4:0]  cdb_id_ROB_i = '0, lsb_cdb_id_ROB_i = '0;
  logic [31:0] cdb_data_i = '0, lsb_cdb_data_i = '0;
  logic        full_o, en_o;
  logic [31:0] A_o, B_o, Imm_o, pc_o;
  logic [6:0]  OP_o, Funct7_o;
  logic [2:0]  Funct3_o;
  logic [4:0]  ROB_id_o;

  int total = 0;
  int bad = 0;
  logic mon_on = 1'b0;
  logic [31:0] cyc = '0;
  logic [REC_W-1:0] exp_q[$];

  rs_alu dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .disp_en_i(disp_en_i),
    .disp_OP_i(disp_OP_i), .disp_Funct7_i(disp_Funct7_i), .disp_Funct3_i(disp_Funct3_i),
    .disp_Imm_i(disp_Imm_i), .disp_pc_i(disp_pc_i), .disp_ROB_id_i(disp_ROB_id_i),
    .disp_Qj_busy_i(disp_Qj_busy_i), .disp_Qj_i(disp_Qj_i), .disp_Vj_i(disp_Vj_i),
    .disp_Qk_busy_i(disp_Qk_busy_i), .disp_Qk_i(disp_Qk_i), .disp_Vk_i(disp_Vk_i),
    .cdb_en_i(cdb_en_i), .cdb_id_ROB_i(cdb_id_ROB_i), .cdb_data_i(cdb_data_i),
    .lsb_cdb_en_i(lsb_cdb_en_i), .lsb_cdb_id_ROB_i(lsb_cdb_id_ROB_i),
    .lsb_cdb_data_i(lsb_cdb_data_i),
    .full_o(full_o), .en_o(en_o), .A_o(A_o), .B_o(B_o), .Imm_o(Imm_o), .pc_o(pc_o),
    .OP_o(OP_o), .Funct7_o(Funct7_o), .Funct3_o(Funct3_o), .ROB_id_o(ROB_id_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Slots hold in-flight ops; the lowest ready slot issues, the lowest empty slot accepts.
  bit          m_busy [DEPTH];
  bit          m_jb   [DEPTH];
  bit          m_kb   [DEPTH];
  logic [4:0]  m_j    [DEPTH];
  logic [4:0]  m_k    [DEPTH];
  logic [31:0] m_vj   [DEPTH];
  logic [31:0] m_vk   [DEPTH];
  logic [31:0] m_imm  [DEPTH];
  logic [31:0] m_pc   [DEPTH];
  logic [6:0]  m_op   [DEPTH];
  logic [6:0]  m_f7   [DEPTH];
  logic [2:0]  m_f3   [DEPTH];
  logic [4:0]  m_rob  [DEPTH];
  int m_iss, m_fr, m_cnt;

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || clear_i) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      m_iss = -1;
      m_fr  = -1;
      m_cnt = model_count();
      for (int i = 0; i < DEPTH; i++) begin
        if (m_iss < 0 && m_busy[i] && !m_jb[i] && !m_kb[i]) m_iss = i;
        if (m_fr < 0 && !m_busy[i]) m_fr = i;
      end
      if (m_iss >= 0) begin
        exp_q.push_back({cyc, m_rob[m_iss], m_vj[m_iss], m_vk[m_iss], m_imm[m_iss],
                         m_pc[m_iss], m_op[m_iss], m_f7[m_iss], m_f3[m_iss]});
        m_busy[m_iss] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && m_jb[i]) begin
          if (cdb_en_i && m_j[i] == cdb_id_ROB_i) begin m_vj[i] = cdb_data_i; m_jb[i] = 1'b0; end
          else if (lsb_cdb_en_i && m_j[i] == lsb_cdb_id_ROB_i) begin m_vj[i] = lsb_cdb_data_i; m_jb[i] = 1'b0; end
        end
        if (m_busy[i] && m_kb[i]) begin
          if (cdb_en_i && m_k[i] == cdb_id_ROB_i) begin m_vk[i] = cdb_data_i; m_kb[i] = 1'b0; end
          else if (lsb_cdb_en_i && m_k[i] == lsb_cdb_id_ROB_i) begin m_vk[i] = lsb_cdb_data_i; m_kb[i] = 1'b0; end
        end
      end
      if (disp_en_i && m_cnt < DEPTH) begin
        m_busy[m_fr] = 1'b1;
        m_j[m_fr] = disp_Qj_i;  m_k[m_fr] = disp_Qk_i;
        m_jb[m_fr] = disp_Qj_busy_i;  m_vj[m_fr] = disp_Vj_i;
        m_kb[m_fr] = disp_Qk_busy_i;  m_vk[m_fr] = disp_Vk_i;
        if (disp_Qj_busy_i && cdb_en_i && disp_Qj_i == cdb_id_ROB_i) begin m_jb[m_fr] = 1'b0; m_vj[m_fr] = cdb_data_i; end
        else if (disp_Qj_busy_i && lsb_cdb_en_i && disp_Qj_i == lsb_cdb_id_ROB_i) begin m_jb[m_fr] = 1'b0; m_vj[m_fr] = lsb_cdb_data_i; end
        if (disp_Qk_busy_i && cdb_en_i && disp_Qk_i == cdb_id_ROB_i) begin m_kb[m_fr] = 1'b0; m_vk[m_fr] = cdb_data_i; end
        else if (disp_Qk_busy_i && lsb_cdb_en_i && disp_Qk_i == lsb_cdb_id_ROB_i) begin m_kb[m_fr] = 1'b0; m_vk[m_fr] = lsb_cdb_data_i; end
        m_imm[m_fr] = disp_Imm_i;  m_pc[m_fr] = disp_pc_i;
        m_op[m_fr] = disp_OP_i;  m_f7[m_fr] = disp_Funct7_i;  m_f3[m_fr] = disp_Funct3_i;
        m_rob[m_fr] = disp_ROB_id_i;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [REC_W-1:0] got_rec, exp_rec;
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (full_o !== (model_count() == DEPTH)) begin
        bad++;
        $display("FAIL full_o cyc=%0d got=%0b required=%0b", cyc, full_o, model_count() == DEPTH);
      end
      got_rec = {cyc, ROB_id_o, A_o, B_o, Imm_o, pc_o, OP_o, Funct7_o, Funct3_o};
      if (en_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_issue cyc=%0d got=%0h required=no issue", cyc, got_rec);
        end else begin
          exp_rec = exp_q.pop_front();
          if (got_rec !== exp_rec) begin
            bad++;
            $display("FAIL issue got=%0h required=%0h", got_rec, exp_rec);
          end
        end
      end else begin
        total++;
        if (en_o !== 1'b0 || {ROB_id_o, A_o, B_o, Imm_o, pc_o, OP_o, Funct7_o, Funct3_o} !== '0) begin
          bad++;
          $display("FAIL idle_bus cyc=%0d en=%b got=%0h required=0", cyc, en_o, got_rec);
        end
        if (exp_q.size() > 0 && exp_q[0][REC_W-1 -: 32] <= cyc) begin
          total++;
          bad++;
          exp_rec = exp_q.pop_front();
          $display("FAIL missing_issue cyc=%0d got=no issue required=%0h", cyc, exp_rec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clk_step();
    @(posedge clk);
    #1;
    disp_en_i = 1'b0; cdb_en_i = 1'b0; lsb_cdb_en_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic set_disp(input logic [6:0] op, input logic [31:0] imm, input logic [4:0] rob,
                          input logic jb, input logic [4:0] qj, input logic [31:0] vj,
                          input logic kb, input logic [4:0] qk, input logic [31:0] vk);
    disp_en_i = 1'b1;  disp_OP_i = op;  disp_Imm_i = imm;  disp_ROB_id_i = rob;
    disp_Funct7_i = $urandom_range(0, 127);  disp_Funct3_i = $urandom_range(0, 7);
    disp_pc_i = $urandom & 32'hffff_fffc;
    disp_Qj_busy_i = jb;  disp_Qj_i = qj;  disp_Vj_i = vj;
    disp_Qk_busy_i = kb;  disp_Qk_i = qk;  disp_Vk_i = vk;
  endtask

  task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
    cdb_en_i = 1'b1; cdb_id_ROB_i = tag; cdb_data_i = data;
  endtask

  task automatic set_lsb(input logic [4:0] tag, input logic [31:0] data);
    lsb_cdb_en_i = 1'b1; lsb_cdb_id_ROB_i = tag; lsb_cdb_data_i = data;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic flush();
    clear_i = 1'b1;
    clk_step();
    clk_step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clk_step();
    clk_step();
    rst = 1'b0;
    mon_on = 1'b1;
    chk("reset_en", en_o, 0);
    chk("reset_full", full_o, 0);

    // ready ADDI: issue exactly one cycle after the dispatch edge
    set_disp(7'b0010011, 7, 3, 0, 0, 5, 0, 0, 0);
    clk_step();
    chk("addi_not_early", en_o, 0);
    clk_step();
    chk("addi_en", en_o, 1);
    chk("addi_A", A_o, 5);
    chk("addi_Imm", Imm_o, 7);
    chk("addi_rob", ROB_id_o, 3);
    clk_step();
    chk("addi_pulse", en_o, 0);

    // wake-up via load CDB
    set_disp(7'b0110011, 0, 6, 1, 9, 0, 0, 0, 2);
    clk_step();
    clk_step();
    set_lsb(9, 32'h100);
    clk_step();
    chk("wake_not_early", en_o, 0);
    clk_step();
    chk("wake_en", en_o, 1);
    chk("wake_A", A_o, 32'h100);
    chk("wake_B", B_o, 2);
    clk_step();

    // dispatch-time bypass from the ALU CDB
    set_disp(7'b0110011, 0, 12, 0, 0, 1, 1, 4, 0);
    set_cdb(4, 32'hDEAD);
    clk_step();
    clk_step();
    chk("bypass_en", en_o, 1);
    chk("bypass_B", B_o, 32'hDEAD);
    clk_step();

    // fill all slots, reject the ninth, then wake 5 and 2 together
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(7'b1100011, i, 5'(i), 1, 5'(8 + i), 0, 0, 0, i);
      clk_step();
    end
    chk("full_set", full_o, 1);
    set_disp(7'b0110111, 99, 31, 0, 0, 0, 0, 0, 0);
    clk_step();
    chk("ninth_full", full_o, 1);
    clk_step();
    chk("ninth_dropped", en_o, 0);
    set_cdb(13, 32'h55);
    set_lsb(10, 32'h22);
    clk_step();
    chk("order_full_hold", full_o, 1);
    clk_step();
    chk("order_first", ROB_id_o, 2);
    chk("order_first_en", en_o, 1);
    chk("full_drop", full_o, 0);
    clk_step();
    chk("order_second", ROB_id_o, 5);
    chk("order_second_A", A_o, 32'h55);
    flush();

    // flush with a concurrent dispatch
    for (int i = 0; i < 4; i++) begin
      set_disp(7'b0110011, 0, 5'(16 + i), 1, 5'(16 + i), 0, 0, 0, 0);
      clk_step();
    end
    clear_i = 1'b1;
    set_disp(7'b0010011, 1, 30, 0, 0, 1, 0, 0, 0);
    clk_step();
    chk("flush_full", full_o, 0);
    chk("flush_en", en_o, 0);
    clk_step();
    chk("flush_drop", en_o, 0);

    // reset mid-operation, then broadcast the old tags
    for (int i = 0; i < 3; i++) begin
      set_disp(7'b0110011, 0, 5'(20 + i), 1, 5'(20 + i), 0, 0, 0, 0);
      clk_step();
    end
    rst = 1'b1;
    clk_step();
    clk_step();
    rst = 1'b0;
    chk("rst_en", en_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_bus", {A_o, B_o}, 0);
    set_cdb(20, 1);
    set_lsb(21, 2);
    clk_step();
    set_cdb(22, 3);
    clk_step();
    clk_step();
    chk("rst_stale", en_o, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 60)
        set_disp($urandom_range(0, 127), $urandom, $urandom_range(0, 31),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 99) < 40) set_cdb($urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 99) < 40) begin
        if (cdb_en_i) set_lsb(5'((cdb_id_ROB_i + $urandom_range(1, 7)) % 8), $urandom);
        else set_lsb($urandom_range(0, 7), $urandom);
      end
      if ($urandom_range(0, 99) < 2) clear_i = 1'b1;
      clk_step();
    end
    clk_step();
    clk_step();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
